clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
- Parametrised multi-channel clock generator. It is the fabric-logic successor to the single-output PLL wrapper.
- Derives NUM_CLOCKS divided, phase-offset, duty-programmable clocks plus per-channel rising-edge ticks from refclk.
- Has a lock/settle FSM and a runtime reconfiguration handshake.
- Sits directly behind the board refclk and feeds slow peripheral domains and clock-enable users.

Parameters:
- NUM_CLOCKS, 4, number of output channels (1..16).
- CNT_W, 16, width of high/low/phase counters.
- LOCK_CYCLES, 1024, refclk cycles spent in SETTLE before locked asserts (>=1).
- DEFAULT_HI, 1, reset high-time (refclk cycles) for every channel.
- DEFAULT_LO, 1, reset low-time (refclk cycles) for every channel.

Ports:
- refclk  in  1  reference clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid & ready.
- cfg_chan  in  4  target channel index.
- cfg_hi  in  CNT_W  high-time in refclk cycles.
- cfg_lo  in  CNT_W  low-time in refclk cycles.
- cfg_phase  in  CNT_W  initial low delay after lock.
- cfg_apply  in  1  single-cycle pulse: commit shadow config and relock.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_chan >= NUM_CLOCKS.
- outclk  out  NUM_CLOCKS  generated clocks (registered).
- tick  out  NUM_CLOCKS  one-cycle pulse per channel on each outclk rise.
- locked  out  1  high while outputs are valid.

Behaviour:
- Reset (async assert, sync deassert by refclk): outclk=0, tick=0, locked=0, cfg_err=0, cfg_ready=0. Shadow and active regs = {DEFAULT_HI, DEFAULT_LO, phase 0}. FSM enters SETTLE with settle counter 0.
- FSM states:
  - SETTLE: counts LOCK_CYCLES cycles, then moves to RUN. In the first RUN cycle locked=1; every channel loads its phase counter in that same cycle.
  - RUN: stays until cfg_apply. On apply, active <= shadow for all channels, then back to SETTLE. locked, outclk and tick are all 0 from the next cycle.
- Channel sequence in RUN: cfg_phase cycles low, then repeating hi cycles high / lo cycles low. Period = hi+lo.
  - With phase=0, outclk rises in the first RUN cycle.
  - tick[c]=1 in exactly the cycles where outclk[c] transitions 0->1.
- All channels restart in lock-step on every RUN entry. Equal configs give identical waveforms.
- Widths:
  - cfg_hi=0 or cfg_lo=0 is coerced to 1 when written into shadow.
  - Counters are CNT_W bits and never wrap. Max period = 2*(2^CNT_W-1).
- cfg_ready=1 in RUN, 0 in SETTLE. A write updates the shadow only; active outputs are unaffected until apply.
- Out-of-range cfg_chan: the write is accepted (handshake completes), no register changes, and cfg_err pulses the next cycle.
- cfg_apply in SETTLE is ignored.
- Write and apply in the same cycle: the write lands first, so the committed config includes it.
- Reset mid-RUN or mid-SETTLE: all outputs go to 0 immediately (asynchronously), shadow is lost, and defaults are restored.

Decomposition:
- Shared package clk_div_pkg holds:
  - chan_cfg_t struct {hi, lo, phase}.
  - FSM state enum {SETTLE, RUN}.
  - Coercion function for zero hi/lo.
- One sub-module, clk_div_chan: per-channel phase/high/low counter with load strobe. It outputs outclk and tick, and is instantiated NUM_CLOCKS times by generate.

Test Plan:
- Reset release, defaults, LOCK_CYCLES=8:
  - locked rises on cycle 9 after rst_n high.
  - outclk[all] toggles every cycle (period 2).
  - tick high on cycles 9, 11, 13...
- Write ch1 hi=3 lo=2 phase=4, then apply:
  - locked drops next cycle and returns after 8.
  - outclk[1] stays low 4 cycles, then shows the pattern 11100 repeating; tick[1] every 5 cycles.
  - ch0 is unchanged, still period 2.
- Write ch2 hi=0 lo=0 and apply: ch2 runs period 2 (coerced). Write cfg_chan=7 with NUM_CLOCKS=4: ready handshake completes, cfg_err pulses 1 cycle, no config change.
- Same-cycle write ch3 hi=5 lo=5 plus apply: after relock, outclk[3] has period 10. An apply pulsed during SETTLE is ignored, and relock timing is unchanged.
- Assert rst_n low mid-RUN for 1 cycle: outclk and locked go 0 asynchronously. After release, defaults are restored and relock takes exactly LOCK_CYCLES.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types for the clock divider bank.
// Holds the per-channel config struct, FSM states and the zero-width coercion.
package clk_div_pkg;

  // Field width of the config struct; the top's CNT_W must match it.
  localparam int CNT_W_PKG = 16;

  typedef logic [CNT_W_PKG-1:0] cnt_t;

  typedef struct packed {
    cnt_t hi;
    cnt_t lo;
    cnt_t phase;
  } chan_cfg_t;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_e;

  // A zero high/low time is meaningless; treat it as one cycle.
  function automatic cnt_t nz(input cnt_t v);
    return (v == '0) ? cnt_t'(1) : v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided clock channel (phase, high, low segments).
// Ports: clk, rst_n, load_i, run_i, hi_i, lo_i, phase_i -> outclk_o, tick_o.
module clk_div_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] hi_i,
  input  logic [CNT_W-1:0] lo_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             outclk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  // cnt_q holds the cycles left in the current segment minus one.
  always_comb begin
    cnt_d  = '0;
    out_d  = 1'b0;
    tick_d = 1'b0;
    if (load_i) begin
      if (phase_i == '0) begin
        out_d  = 1'b1;
        tick_d = 1'b1;
        cnt_d  = hi_i - 1'b1;
      end else begin
        cnt_d  = phase_i - 1'b1;
      end
    end else if (run_i) begin
      if (cnt_q != '0) begin
        out_d = out_q;
        cnt_d = cnt_q - 1'b1;
      end else if (out_q) begin
        cnt_d = lo_i - 1'b1;
      end else begin
        out_d  = 1'b1;
        tick_d = 1'b1;
        cnt_d  = hi_i - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign outclk_o = out_q;
  assign tick_o   = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CLOCKS divided clocks with lock FSM and config handshake.
// Ports: refclk, rst_n, cfg_* write/apply in; cfg_ready, cfg_err, outclk, tick, locked out.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int CNT_W       = CNT_W_PKG,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_HI  = 1,
  parameter int DEFAULT_LO  = 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [CNT_W-1:0]      cfg_hi,
  input  logic [CNT_W-1:0]      cfg_lo,
  input  logic [CNT_W-1:0]      cfg_phase,
  input  logic                  cfg_apply,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(LOCK_CYCLES - 1);

  localparam chan_cfg_t DEF = '{
    hi:    nz(cnt_t'(DEFAULT_HI)),
    lo:    nz(cnt_t'(DEFAULT_LO)),
    phase: '0
  };

  state_e          state_q;
  logic [SW-1:0]   settle_q;
  logic            locked_q;
  logic            err_q;
  chan_cfg_t       shadow_q [NUM_CLOCKS];
  chan_cfg_t       shadow_d [NUM_CLOCKS];
  chan_cfg_t       active_q [NUM_CLOCKS];

  logic wr, in_range, lock_done, run;

  assign cfg_ready = (state_q == RUN);
  assign wr        = cfg_valid & cfg_ready;
  assign in_range  = int'(cfg_chan) < NUM_CLOCKS;
  assign lock_done = (state_q == SETTLE) && (settle_q == LAST);
  // Channels stop on the apply edge so outputs are low from the next cycle.
  assign run       = (state_q == RUN) && !cfg_apply;

  // Shadow next-state includes this cycle's write so apply commits it.
  always_comb begin
    for (int c = 0; c < NUM_CLOCKS; c++) begin
      shadow_d[c] = shadow_q[c];
      if (wr && int'(cfg_chan) == c) begin
        shadow_d[c] = '{hi: nz(cfg_hi), lo: nz(cfg_lo), phase: cfg_phase};
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      for (int c = 0; c < NUM_CLOCKS; c++) begin
        shadow_q[c] <= DEF;
        active_q[c] <= DEF;
      end
    end else begin
      err_q <= wr && !in_range;
      for (int c = 0; c < NUM_CLOCKS; c++) begin
        shadow_q[c] <= shadow_d[c];
      end
      case (state_q)
        SETTLE: begin
          if (lock_done) begin
            state_q  <= RUN;
            locked_q <= 1'b1;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        RUN: begin
          if (cfg_apply) begin
            state_q  <= SETTLE;
            locked_q <= 1'b0;
            settle_q <= '0;
            for (int c = 0; c < NUM_CLOCKS; c++) begin
              active_q[c] <= shadow_d[c];
            end
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign locked  = locked_q;
  assign cfg_err = err_q;

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (refclk),
      .rst_n    (rst_n),
      .load_i   (lock_done),
      .run_i    (run),
      .hi_i     (active_q[g].hi),
      .lo_i     (active_q[g].lo),
      .phase_i  (active_q[g].phase),
      .outclk_o (outclk[g]),
      .tick_o   (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: randomized and directed checks of clk_div_bank
// against a waveform-level reference model.
module tb_clk_div_bank;

  localparam int NC = 4;
  localparam int W  = 16;
  localparam int LK = 8;

  logic          refclk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready, cfg_apply, cfg_err;
  logic [3:0]    cfg_chan;
  logic [W-1:0]  cfg_hi, cfg_lo, cfg_phase;
  logic [NC-1:0] outclk, tick;
  logic          locked;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit m_run, m_err;
  int m_settle, m_k;
  int sh_hi[NC], sh_lo[NC], sh_ph[NC];
  int ac_hi[NC], ac_lo[NC], ac_ph[NC];

  clk_div_bank #(
    .NUM_CLOCKS  (NC),
    .CNT_W       (W),
    .LOCK_CYCLES (LK),
    .DEFAULT_HI  (1),
    .DEFAULT_LO  (1)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_hi    (cfg_hi),
    .cfg_lo    (cfg_lo),
    .cfg_phase (cfg_phase),
    .cfg_apply (cfg_apply),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .tick      (tick),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 0; m_settle = 0; m_k = 0;
    for (int c = 0; c < NC; c++) begin
      sh_hi[c] = 1; sh_lo[c] = 1; sh_ph[c] = 0;
      ac_hi[c] = 1; ac_lo[c] = 1; ac_ph[c] = 0;
    end
  endtask

  task automatic model_step();
    bit wr;
    int ch;
    ch = int'(cfg_chan);
    wr = cfg_valid && m_run;
    m_err = wr && (ch >= NC);
    if (wr && ch < NC) begin
      sh_hi[ch] = (cfg_hi == 0) ? 1 : int'(cfg_hi);
      sh_lo[ch] = (cfg_lo == 0) ? 1 : int'(cfg_lo);
      sh_ph[ch] = int'(cfg_phase);
    end
    if (m_run) begin
      if (cfg_apply) begin
        ac_hi = sh_hi; ac_lo = sh_lo; ac_ph = sh_ph;
        m_run = 0;
        m_settle = 0;
      end else begin
        m_k++;
      end
    end else begin
      m_settle++;
      if (m_settle == LK) begin
        m_run = 1;
        m_k = 0;
      end
    end
  endtask

  // k = cycles since the first RUN cycle
  task automatic check_all();
    logic [NC-1:0] eo, et;
    int p, r;
    eo = '0; et = '0;
    for (int c = 0; c < NC; c++) begin
      p = ac_hi[c] + ac_lo[c];
      if (m_run && m_k >= ac_ph[c]) begin
        r = (m_k - ac_ph[c]) % p;
        eo[c] = (r < ac_hi[c]);
        et[c] = (r == 0);
      end
    end
    chk("locked", 32'(locked), 32'(m_run));
    chk("ready", 32'(cfg_ready), 32'(m_run));
    chk("err", 32'(cfg_err), 32'(m_err));
    chk("outclk", 32'(outclk), 32'(eo));
    chk("tick", 32'(tick), 32'(et));
  endtask

  task automatic cyc();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    check_all();
  endtask

  task automatic idle();
    cfg_valid = 0; cfg_apply = 0;
    cfg_chan = '0; cfg_hi = '0; cfg_lo = '0; cfg_phase = '0;
  endtask

  task automatic write(input int ch, input int hi, input int lo,
                       input int ph, input bit ap);
    cfg_valid = 1; cfg_apply = ap;
    cfg_chan = 4'(ch); cfg_hi = W'(hi); cfg_lo = W'(lo); cfg_phase = W'(ph);
    cyc();
    idle();
  endtask

  task automatic apply();
    cfg_apply = 1;
    cyc();
    cfg_apply = 0;
  endtask

  // counts cycles until locked, bounded
  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 100) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n;
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge refclk);
    chk("rst_outclk", 32'(outclk), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_err", 32'(cfg_err), 0);
    rst_n = 1;

    wait_lock(n);
    chk("lock_lat", n, LK);
    repeat (10) cyc();

    write(1, 3, 2, 4, 0);
    apply();
    wait_lock(n);
    chk("relock_lat", n, LK);
    repeat (25) cyc();

    write(2, 0, 0, 0, 0);
    write(7, 9, 9, 9, 0);
    apply();
    wait_lock(n);
    repeat (10) cyc();

    write(3, 5, 5, 0, 1);
    repeat (3) cyc();
    apply();
    wait_lock(n);
    chk("settle_apply_ign", n, LK - 4);
    repeat (25) cyc();

    for (int i = 0; i < 400; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 4'($urandom_range(0, 7));
      cfg_hi    = W'($urandom_range(0, 6));
      cfg_lo    = W'($urandom_range(0, 6));
      cfg_phase = W'($urandom_range(0, 5));
      cfg_apply = ($urandom_range(0, 24) == 0);
      cyc();
    end
    idle();

    wait_lock(n);
    repeat (5) cyc();
    rst_n = 0;
    #1;
    chk("async_outclk", 32'(outclk), 0);
    chk("async_locked", 32'(locked), 0);
    chk("async_tick", 32'(tick), 0);
    model_reset();
    @(posedge refclk);
    @(negedge refclk);
    rst_n = 1;
    wait_lock(n);
    chk("rst_relock_lat", n, LK);
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
